// File: rtl/trigger_burst_gen.sv
// Expands each synchronised L1 trigger edge into a burst of Trigger_Count active cycles, with optional pending queue and TMR state.
// Latency: input rise -> Trig_Active after 3 clocks; no backpressure, L1_Reg_Full rejects new edges and only gates L1Trig_Out.
module trigger_burst_gen #(
    parameter int CNT_W      = 4,
    parameter int PEND_DEPTH = 4,
    parameter int TAG_W      = 5,
    parameter int TMR        = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             L1_Trig_In,
    input  logic [CNT_W-1:0] Trigger_Count,
    input  logic             Mode,
    input  logic             L1_Reg_Full,
    output logic             Trig_Active,
    output logic             L1Trig_Out,
    output logic             Trig_First,
    output logic [TAG_W-1:0] Trig_Tag,
    output logic [3:0]       Pend_Count,
    output logic             Trig_Dropped,
    output logic [7:0]       Drop_Count
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    localparam logic [CNT_W:0]   CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [TAG_W-1:0] TAG_ONE  = {{(TAG_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       PEND_MAX = 4'(PEND_DEPTH);

    // Every piece of state lives in one packed word so it can be replicated and voted as a unit.
    typedef struct packed {
        logic             s1;
        logic             s2;
        logic             s3;
        logic [0:0]       state;
        logic [CNT_W:0]   cnt;
        logic [TAG_W-1:0] tag;
        logic [TAG_W-1:0] next_tag;
        logic [3:0]       pend;
        logic             first;
        logic             dropped;
        logic [7:0]       drop_cnt;
    } st_t;

    localparam int SW = $bits(st_t);
    // Sync chain occupies the top three bits and resets high so a level held through reset is not an edge.
    localparam logic [SW-1:0] RST_VEC = {3'b111, {(SW-3){1'b0}}};

    logic [SW-1:0] st_q;
    logic [SW-1:0] st_d;
    st_t           cur;
    st_t           nxt;

    logic           trig_edge;
    logic           accept;
    logic           last;
    logic           start;
    logic           enq;
    logic           deq;
    logic           drop;
    logic [CNT_W:0] load_val;

    assign cur = st_q;

    always_comb begin
        trig_edge = cur.s2 & ~cur.s3;
        accept    = trig_edge & ~L1_Reg_Full;
        last      = (cur.state == S_BURST) && (cur.cnt == CNT_ONE);
        load_val  = (Trigger_Count == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, Trigger_Count};
        start     = 1'b0;
        enq       = 1'b0;
        deq       = 1'b0;
        drop      = 1'b0;

        if (cur.state == S_IDLE) begin
            start = accept;
            drop  = trig_edge & ~accept;
        end else if (last) begin
            if (cur.pend != 4'd0) begin
                // Consuming one entry this cycle always frees room for a same-cycle edge.
                start = 1'b1;
                deq   = 1'b1;
                enq   = accept & Mode;
                drop  = trig_edge & ~enq;
            end else begin
                start = accept;
                drop  = trig_edge & ~accept;
            end
        end else begin
            enq  = accept & Mode & (cur.pend < PEND_MAX);
            drop = trig_edge & ~enq;
        end

        nxt         = cur;
        nxt.s1      = L1_Trig_In;
        nxt.s2      = cur.s1;
        nxt.s3      = cur.s2;
        nxt.pend    = cur.pend + {3'b000, enq} - {3'b000, deq};
        nxt.first   = start;
        nxt.dropped = drop;
        if (drop && (cur.drop_cnt != 8'hFF)) begin
            nxt.drop_cnt = cur.drop_cnt + 8'd1;
        end

        if (start) begin
            nxt.state    = S_BURST;
            nxt.cnt      = load_val;
            nxt.tag      = cur.next_tag;
            nxt.next_tag = cur.next_tag + TAG_ONE;
        end else if (cur.state == S_BURST) begin
            nxt.cnt = cur.cnt - CNT_ONE;
            if (last) begin
                nxt.state = S_IDLE;
            end
        end
    end

    assign st_d = nxt;

    if (TMR != 0) begin : g_tmr
        logic [SW-1:0] rep0_q;
        logic [SW-1:0] rep1_q;
        logic [SW-1:0] rep2_q;

        // All copies reload from the voted next state, so an upset copy is scrubbed on the next edge.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                rep0_q <= RST_VEC;
                rep1_q <= RST_VEC;
                rep2_q <= RST_VEC;
            end else begin
                rep0_q <= st_d;
                rep1_q <= st_d;
                rep2_q <= st_d;
            end
        end

        assign st_q = (rep0_q & rep1_q) | (rep0_q & rep2_q) | (rep1_q & rep2_q);
    end else begin : g_single
        logic [SW-1:0] rep0_q;

        always_ff @(posedge Clk) begin
            if (Reset) begin
                rep0_q <= RST_VEC;
            end else begin
                rep0_q <= st_d;
            end
        end

        assign st_q = rep0_q;
    end

    assign Trig_Active  = (cur.state == S_BURST);
    assign L1Trig_Out   = Trig_Active & ~L1_Reg_Full;
    assign Trig_First   = cur.first;
    assign Trig_Tag     = cur.tag;
    assign Pend_Count   = cur.pend;
    assign Trig_Dropped = cur.dropped;
    assign Drop_Count   = cur.drop_cnt;

endmodule

// File: tb/tb_trigger_burst_gen.sv
// Scoreboarded bench: driver runs a timeline reference model and queues expected outputs; monitor compares each cycle.
module tb_trigger_burst_gen;

    localparam int CNT_W      = 4;
    localparam int PEND_DEPTH = 4;
    localparam int TAG_W      = 5;

    logic             clk;
    logic             Reset;
    logic             L1_Trig_In;
    logic [CNT_W-1:0] Trigger_Count;
    logic             Mode;
    logic             L1_Reg_Full;
    logic             Trig_Active;
    logic             L1Trig_Out;
    logic             Trig_First;
    logic [TAG_W-1:0] Trig_Tag;
    logic [3:0]       Pend_Count;
    logic             Trig_Dropped;
    logic [7:0]       Drop_Count;

    trigger_burst_gen #(
        .CNT_W(CNT_W), .PEND_DEPTH(PEND_DEPTH), .TAG_W(TAG_W), .TMR(1)
    ) dut (
        .Clk(clk),
        .Reset(Reset),
        .L1_Trig_In(L1_Trig_In),
        .Trigger_Count(Trigger_Count),
        .Mode(Mode),
        .L1_Reg_Full(L1_Reg_Full),
        .Trig_Active(Trig_Active),
        .L1Trig_Out(L1Trig_Out),
        .Trig_First(Trig_First),
        .Trig_Tag(Trig_Tag),
        .Pend_Count(Pend_Count),
        .Trig_Dropped(Trig_Dropped),
        .Drop_Count(Drop_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             act;
        logic             l1o;
        logic             first;
        logic [TAG_W-1:0] tag;
        logic [3:0]       pend;
        logic             drp;
        logic [7:0]       dcnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: bursts are intervals [start, burst_end) of posedge indices.
    int k_cyc     = 0;
    int burst_end = 0;
    int pend      = 0;
    int cur_tag   = 0;
    int next_tag  = 0;
    int dcnt      = 0;
    bit h1 = 1'b1, h2 = 1'b1, h3 = 1'b1;

    task automatic step(input bit rst, input bit tin, input bit full, input bit md, input bit [3:0] tc);
        exp_t e;
        bit   ev, started, dropped, in_burst, last;
        @(negedge clk);
        Reset = rst; L1_Trig_In = tin; L1_Reg_Full = full; Mode = md; Trigger_Count = tc;
        k_cyc++;
        started = 1'b0;
        dropped = 1'b0;
        if (rst) begin
            h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
            burst_end = k_cyc; pend = 0; cur_tag = 0; next_tag = 0; dcnt = 0;
        end else begin
            ev       = h2 && !h3;
            in_burst = (k_cyc - 1) < burst_end;
            last     = (k_cyc - 1) == (burst_end - 1);
            if (!in_burst) begin
                if (ev && !full) started = 1'b1;
                else if (ev) dropped = 1'b1;
            end else if (last && pend > 0) begin
                started = 1'b1;
                pend--;
                if (ev && !full && md) pend++;
                else if (ev) dropped = 1'b1;
            end else if (last) begin
                if (ev && !full) started = 1'b1;
                else if (ev) dropped = 1'b1;
            end else if (ev) begin
                if (!full && md && pend < PEND_DEPTH) pend++;
                else dropped = 1'b1;
            end
            if (started) begin
                burst_end = k_cyc + ((tc == 0) ? (1 << CNT_W) : int'(tc));
                cur_tag   = next_tag;
                next_tag  = (next_tag + 1) % (1 << TAG_W);
            end
            if (dropped && dcnt < 255) dcnt++;
            h3 = h2; h2 = h1; h1 = tin;
        end
        e.act   = k_cyc < burst_end;
        e.l1o   = e.act && !full;
        e.first = started;
        e.tag   = TAG_W'(cur_tag);
        e.pend  = 4'(pend);
        e.drp   = dropped;
        e.dcnt  = 8'(dcnt);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit md, input bit [3:0] tc);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, md, tc);
    endtask

    // Monitor: every cycle the DUT presents a full output word; compare it against the oldest expectation.
    initial begin : monitor
        exp_t e;
        exp_t g;
        int   mon_idx;
        mon_idx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g.act = Trig_Active; g.l1o = L1Trig_Out; g.first = Trig_First; g.tag = Trig_Tag;
                g.pend = Pend_Count; g.drp = Trig_Dropped; g.dcnt = Drop_Count;
                mon_idx++;
                tests++;
                if (g !== e) begin
                    fails++;
                    $display("FAIL cycle %0d: got act=%0b l1o=%0b first=%0b tag=%0d pend=%0d drop=%0b dcnt=%0d, expected act=%0b l1o=%0b first=%0b tag=%0d pend=%0d drop=%0b dcnt=%0d",
                             mon_idx, g.act, g.l1o, g.first, g.tag, g.pend, g.drp, g.dcnt,
                             e.act, e.l1o, e.first, e.tag, e.pend, e.drp, e.dcnt);
                end
            end
        end
    end

    initial begin : driver
        bit md;
        int dens;
        Reset = 1'b1; L1_Trig_In = 1'b0; L1_Reg_Full = 1'b0; Mode = 1'b0; Trigger_Count = 4'd3;

        // Reset state, then a single 3-cycle burst.
        step(1, 0, 0, 0, 4'd3); step(1, 0, 0, 0, 4'd3);
        step(0, 1, 0, 0, 4'd3); idle(8, 0, 4'd3);
        // Trigger_Count=0 gives a 16-cycle burst.
        step(0, 1, 0, 0, 4'd0); idle(22, 0, 4'd0);
        // Queued triggers run back-to-back.
        for (int i = 0; i < 6; i++) step(0, (i % 2 == 0), 0, 1, 4'd4);
        idle(16, 1, 4'd4);
        // Mode 0 drops a mid-burst edge.
        step(0, 1, 0, 0, 4'd6); idle(2, 0, 4'd6); step(0, 1, 0, 0, 4'd6); idle(10, 0, 4'd6);
        // Fill the queue, hit the last burst cycle, then overflow mid-burst.
        for (int i = 0; i < 14; i++) step(0, (i % 2 == 0), 0, 1, 4'd10);
        idle(70, 1, 4'd10);
        // Register full at edge time, then full mid-burst.
        step(0, 1, 1, 0, 4'd3); step(0, 0, 1, 0, 4'd3); step(0, 0, 1, 0, 4'd3); step(0, 0, 1, 0, 4'd3);
        idle(3, 0, 4'd3);
        for (int i = 0; i < 12; i++) step(0, (i == 0), (i >= 4 && i < 7), 0, 4'd5);
        // Input held high across reset.
        step(1, 1, 0, 0, 4'd3); step(1, 1, 0, 0, 4'd3);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 4'd3);
        idle(6, 0, 4'd3);
        // Reset mid-burst with two pending.
        for (int i = 0; i < 7; i++) step(0, (i % 2 == 0 && i < 5), 0, 1, 4'd8);
        step(1, 0, 0, 1, 4'd8); idle(15, 1, 4'd8);
        // Upset one state copy, then a different copy next time; scrubbing keeps outputs intact.
        step(0, 1, 0, 0, 4'd12); idle(4, 0, 4'd12);
        force dut.g_tmr.rep1_q = '1;
        @(posedge clk); #2;
        release dut.g_tmr.rep1_q;
        idle(2, 0, 4'd12);
        force dut.g_tmr.rep2_q = '1;
        @(posedge clk); #2;
        release dut.g_tmr.rep2_q;
        idle(14, 0, 4'd12);
        // Drop counter saturation.
        for (int i = 0; i < 1200; i++) step(0, (i % 2 == 0), 0, 0, 4'd0);
        idle(20, 0, 4'd0);
        // Randomised traffic.
        md = 1'b0;
        dens = 3;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                md   = 1'($urandom_range(0, 1));
                dens = $urandom_range(1, 6);
            end
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, dens) == 0),
                 ($urandom_range(0, 7) == 0), md, 4'($urandom_range(0, 7)));
        end
        idle(20, 0, 4'd3);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
